// File: rtl/PARAMS_pkg.sv
// Shared widths, defaults and types for the write-back port arbiter and its
// long-unit result buffer.
package PARAMS_pkg;

  localparam int unsigned WD_SIZE            = 32;
  localparam int unsigned INSTR_REG_BITS     = 5;
  localparam int unsigned FIFO_DEPTH_DEFAULT = 2;
  localparam int unsigned STARVE_MAX_DEFAULT = 4;

  typedef struct packed {
    logic [INSTR_REG_BITS-1:0] rd;
    logic [WD_SIZE-1:0]        data;
  } wb_req_t;

  typedef enum logic {
    NORMAL = 1'b0,
    DRAIN  = 1'b1
  } arb_state_t;

  // r0 is hard-wired, so any write aimed at it is dropped.
  function automatic logic rd_is_zero(input logic [INSTR_REG_BITS-1:0] rd);
    return rd == '0;
  endfunction

endpackage

// File: rtl/wb_result_fifo.sv
// Small in-order buffer for long-unit results. Each entry carries a kill bit
// so a younger pipeline write to the same register can squash it in place.
module wb_result_fifo
  import PARAMS_pkg::*;
#(
  parameter int unsigned DEPTH = FIFO_DEPTH_DEFAULT
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      push,
  input  logic [INSTR_REG_BITS-1:0] push_rd,
  input  logic [WD_SIZE-1:0]        push_data,
  input  logic                      pop,
  input  logic                      kill_en,
  input  logic [INSTR_REG_BITS-1:0] kill_rd,
  output logic                      head_valid,
  output logic                      head_kill,
  output logic [INSTR_REG_BITS-1:0] head_rd,
  output logic [WD_SIZE-1:0]        head_data,
  output logic                      ready,
  output logic                      busy
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  wb_req_t          mem [DEPTH];
  logic [DEPTH-1:0] kill_q;
  logic [PW-1:0]    wr_ptr_q;
  logic [PW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    count_d;
  logic             ready_q;
  logic             busy_q;
  logic             do_push;
  logic             do_pop;

  assign head_valid = (count_q != '0);
  assign head_kill  = kill_q[rd_ptr_q];
  assign head_rd    = mem[rd_ptr_q].rd;
  assign head_data  = mem[rd_ptr_q].data;
  assign ready      = ready_q;
  assign busy       = busy_q;

  assign do_pop  = pop && head_valid;
  assign do_push = push && (count_q != CW'(DEPTH));

  always_comb begin
    count_d = count_q;
    if (do_push && !do_pop) begin
      count_d = count_q + CW'(1);
    end else if (!do_push && do_pop) begin
      count_d = count_q - CW'(1);
    end
  end

  // Kill bits on free slots are harmless: a push always clears its slot's bit,
  // which is also what keeps a same-cycle push out of the squash.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      kill_q   <= '0;
      ready_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      ready_q <= (count_d != CW'(DEPTH));
      busy_q  <= (count_d != '0);
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + PW'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (do_push && (wr_ptr_q == PW'(i))) begin
          kill_q[i] <= 1'b0;
        end else if (kill_en && (mem[i].rd == kill_rd)) begin
          kill_q[i] <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_q] <= '{rd: push_rd, data: push_data};
    end
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the register-file write port between the in-order write-back stream
// (fixed priority) and buffered long-unit results, with forced drain on starvation.
module wb_port_arbiter
  import PARAMS_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEFAULT,
  parameter int unsigned STARVE_MAX = STARVE_MAX_DEFAULT
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      wb_valid_i,
  input  logic [INSTR_REG_BITS-1:0] wb_rd_i,
  input  logic [WD_SIZE-1:0]        wb_data_i,
  input  logic                      lu_valid_i,
  input  logic [INSTR_REG_BITS-1:0] lu_rd_i,
  input  logic [WD_SIZE-1:0]        lu_data_i,
  output logic                      lu_ready_o,
  output logic                      stall_o,
  output logic                      rf_we_o,
  output logic [INSTR_REG_BITS-1:0] rf_rd_o,
  output logic [WD_SIZE-1:0]        rf_data_o,
  output logic                      busy_o
);

  localparam int unsigned SW = (STARVE_MAX > 1) ? $clog2(STARVE_MAX) : 1;

  arb_state_t                state_q;
  arb_state_t                state_d;
  logic [SW-1:0]             starve_q;
  logic [SW-1:0]             starve_d;
  logic                      stall_q;
  logic                      rf_we_q;
  logic [INSTR_REG_BITS-1:0] rf_rd_q;
  logic [WD_SIZE-1:0]        rf_data_q;

  logic                      pipe_req;
  logic                      grant_pipe;
  logic                      grant_fifo;
  logic                      fifo_push;
  logic                      fifo_pop;
  logic                      kill_en;
  logic                      head_valid;
  logic                      head_kill;
  logic                      head_live;
  logic                      head_dead;
  logic [INSTR_REG_BITS-1:0] head_rd;
  logic [WD_SIZE-1:0]        head_data;
  logic                      fifo_ready;
  logic                      fifo_busy;

  // rd==0 results are still handshaken so the long unit never blocks on them.
  assign fifo_push = lu_valid_i && fifo_ready && !rd_is_zero(lu_rd_i);

  wb_result_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (fifo_push),
    .push_rd    (lu_rd_i),
    .push_data  (lu_data_i),
    .pop        (fifo_pop),
    .kill_en    (kill_en),
    .kill_rd    (wb_rd_i),
    .head_valid (head_valid),
    .head_kill  (head_kill),
    .head_rd    (head_rd),
    .head_data  (head_data),
    .ready      (fifo_ready),
    .busy       (fifo_busy)
  );

  assign pipe_req  = wb_valid_i && !rd_is_zero(wb_rd_i);
  assign head_live = head_valid && !head_kill;
  assign head_dead = head_valid && head_kill;

  always_comb begin
    state_d    = state_q;
    starve_d   = starve_q;
    grant_pipe = 1'b0;
    grant_fifo = 1'b0;
    fifo_pop   = 1'b0;
    kill_en    = 1'b0;
    unique case (state_q)
      NORMAL: begin
        if (pipe_req) begin
          grant_pipe = 1'b1;
          kill_en    = 1'b1;
          if (head_dead) begin
            fifo_pop = 1'b1;
            starve_d = '0;
          end else if (head_live) begin
            if (starve_q == SW'(STARVE_MAX - 1)) begin
              state_d  = DRAIN;
              starve_d = '0;
            end else begin
              starve_d = starve_q + SW'(1);
            end
          end
        end else if (head_valid) begin
          fifo_pop   = 1'b1;
          grant_fifo = !head_kill;
          starve_d   = '0;
        end
      end
      DRAIN: begin
        // A head squashed on the way in is simply discarded here.
        state_d  = NORMAL;
        starve_d = '0;
        if (head_valid) begin
          fifo_pop   = 1'b1;
          grant_fifo = !head_kill;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= NORMAL;
      starve_q  <= '0;
      stall_q   <= 1'b0;
      rf_we_q   <= 1'b0;
      rf_rd_q   <= '0;
      rf_data_q <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      stall_q  <= (state_d == DRAIN);
      rf_we_q  <= grant_pipe || grant_fifo;
      if (grant_pipe) begin
        rf_rd_q   <= wb_rd_i;
        rf_data_q <= wb_data_i;
      end else if (grant_fifo) begin
        rf_rd_q   <= head_rd;
        rf_data_q <= head_data;
      end
    end
  end

  assign lu_ready_o = fifo_ready;
  assign busy_o     = fifo_busy;
  assign stall_o    = stall_q;
  assign rf_we_o    = rf_we_q;
  assign rf_rd_o    = rf_rd_q;
  assign rf_data_o  = rf_data_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Scoreboard bench for wb_port_arbiter: expected register-file writes are queued
// as stimulus is driven and matched in order whenever rf_we_o is seen.
module tb_wb_port_arbiter;
  import PARAMS_pkg::*;

  typedef logic [INSTR_REG_BITS+WD_SIZE-1:0] wr_t;

  logic                      clk = 1'b0;
  logic                      reset;
  logic                      wb_valid_i;
  logic [INSTR_REG_BITS-1:0] wb_rd_i;
  logic [WD_SIZE-1:0]        wb_data_i;
  logic                      lu_valid_i;
  logic [INSTR_REG_BITS-1:0] lu_rd_i;
  logic [WD_SIZE-1:0]        lu_data_i;
  logic                      lu_ready_o;
  logic                      stall_o;
  logic                      rf_we_o;
  logic [INSTR_REG_BITS-1:0] rf_rd_o;
  logic [WD_SIZE-1:0]        rf_data_o;
  logic                      busy_o;

  wr_t         exp_q[$];
  int unsigned errors = 0;
  int unsigned checks = 0;

  wb_port_arbiter #(
    .FIFO_DEPTH (2),
    .STARVE_MAX (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .wb_valid_i (wb_valid_i),
    .wb_rd_i    (wb_rd_i),
    .wb_data_i  (wb_data_i),
    .lu_valid_i (lu_valid_i),
    .lu_rd_i    (lu_rd_i),
    .lu_data_i  (lu_data_i),
    .lu_ready_o (lu_ready_o),
    .stall_o    (stall_o),
    .rf_we_o    (rf_we_o),
    .rf_rd_o    (rf_rd_o),
    .rf_data_o  (rf_data_o),
    .busy_o     (busy_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic exp_push(input logic [INSTR_REG_BITS-1:0] rd, input logic [WD_SIZE-1:0] d);
    exp_q.push_back({rd, d});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    wb_valid_i = 1'b0;
    lu_valid_i = 1'b0;
  endtask

  task automatic idle_cycles(input int unsigned n);
    repeat (n) begin
      step();
      idle_inputs();
      sample();
    end
  endtask

  task automatic drive_wb(input logic [INSTR_REG_BITS-1:0] rd, input logic [WD_SIZE-1:0] d);
    wb_valid_i = 1'b1;
    wb_rd_i    = rd;
    wb_data_i  = d;
  endtask

  task automatic drive_lu(input logic [INSTR_REG_BITS-1:0] rd, input logic [WD_SIZE-1:0] d);
    lu_valid_i = 1'b1;
    lu_rd_i    = rd;
    lu_data_i  = d;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_we"},    64'(rf_we_o),    64'(0));
    check({tag, "_rd"},    64'(rf_rd_o),    64'(0));
    check({tag, "_data"},  64'(rf_data_o),  64'(0));
    check({tag, "_stall"}, 64'(stall_o),    64'(0));
    check({tag, "_ready"}, 64'(lu_ready_o), 64'(0));
    check({tag, "_busy"},  64'(busy_o),     64'(0));
  endtask

  always @(negedge clk) begin
    if (rf_we_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexp_wr", 64'(rf_we_o), 64'(0));
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("wr", 64'({rf_rd_o, rf_data_o}), 64'(e));
      end
    end
  end

  initial begin
    reset      = 1'b1;
    wb_valid_i = 1'b0;
    wb_rd_i    = '0;
    wb_data_i  = '0;
    lu_valid_i = 1'b0;
    lu_rd_i    = '0;
    lu_data_i  = '0;

    step(); sample();
    check_all_zero("rst");
    step(); reset = 1'b0; sample();
    check("rdy_rel0", 64'(lu_ready_o), 64'(0));
    step(); sample();
    check("rdy_rel1", 64'(lu_ready_o), 64'(1));

    // Pipeline only
    step(); drive_wb(5'd5, 32'hDEADBEEF); exp_push(5'd5, 32'hDEADBEEF); sample();
    check("p_ready", 64'(lu_ready_o), 64'(1));
    step(); idle_inputs(); sample();
    check("p_we", 64'(rf_we_o), 64'(1));
    check("p_ready2", 64'(lu_ready_o), 64'(1));
    step(); sample();
    check("p_we_off", 64'(rf_we_o), 64'(0));

    // Long unit with idle pipeline
    step(); drive_lu(5'd7, 32'h12); exp_push(5'd7, 32'h12); sample();
    step(); idle_inputs(); sample();
    check("lu_busy1", 64'(busy_o), 64'(1));
    check("lu_we0", 64'(rf_we_o), 64'(0));
    step(); sample();
    check("lu_busy0", 64'(busy_o), 64'(0));
    check("lu_we1", 64'(rf_we_o), 64'(1));
    idle_cycles(2);

    // Starvation: four ungranted cycles, one DRAIN cycle, pipeline holds D4
    for (int i = 0; i < 4; i++) exp_push(5'd1, 32'h100 + 32'(i));
    exp_push(5'd3, 32'h33);
    exp_push(5'd1, 32'h104);
    exp_push(5'd1, 32'h105);
    step(); drive_lu(5'd3, 32'h33); sample();
    for (int i = 0; i < 4; i++) begin
      step(); lu_valid_i = 1'b0; drive_wb(5'd1, 32'h100 + 32'(i)); sample();
      check("st_nostall", 64'(stall_o), 64'(0));
    end
    step(); drive_wb(5'd1, 32'h104); sample();
    check("st_stall", 64'(stall_o), 64'(1));
    step(); drive_wb(5'd1, 32'h104); sample();
    check("st_stall_off", 64'(stall_o), 64'(0));
    check("st_drain_rd", 64'(rf_rd_o), 64'(3));
    step(); drive_wb(5'd1, 32'h105); sample();
    idle_cycles(3);

    // Full FIFO while pipeline busy; third result waits for a pop
    exp_push(5'd2, 32'hE0);
    exp_push(5'd2, 32'hE1);
    exp_push(5'd2, 32'hE2);
    exp_push(5'd10, 32'hA0);
    exp_push(5'd11, 32'hB0);
    exp_push(5'd12, 32'hC0);
    step(); drive_wb(5'd2, 32'hE0); drive_lu(5'd10, 32'hA0); sample();
    step(); drive_wb(5'd2, 32'hE1); drive_lu(5'd11, 32'hB0); sample();
    check("ff_ready1", 64'(lu_ready_o), 64'(1));
    step(); drive_wb(5'd2, 32'hE2); drive_lu(5'd12, 32'hC0); sample();
    check("ff_full", 64'(lu_ready_o), 64'(0));
    step(); wb_valid_i = 1'b0; sample();
    check("ff_full_pop", 64'(lu_ready_o), 64'(0));
    step(); sample();
    check("ff_ready_again", 64'(lu_ready_o), 64'(1));
    check("ff_busy", 64'(busy_o), 64'(1));
    step(); lu_valid_i = 1'b0; sample();
    idle_cycles(3);

    // Squash: older r9 result killed, discarded alongside a pipeline write
    exp_push(5'd9, 32'hBB);
    exp_push(5'd6, 32'h66);
    step(); drive_lu(5'd9, 32'hAA); sample();
    step(); lu_valid_i = 1'b0; drive_wb(5'd9, 32'hBB); sample();
    check("sq_busy1", 64'(busy_o), 64'(1));
    step(); drive_wb(5'd6, 32'h66); sample();
    check("sq_busy_killed", 64'(busy_o), 64'(1));
    step(); idle_inputs(); sample();
    check("sq_busy0", 64'(busy_o), 64'(0));
    step(); sample();
    check("sq_no_wr", 64'(rf_we_o), 64'(0));

    // Same-cycle push to the granted rd is not squashed
    exp_push(5'd9, 32'hDD);
    exp_push(5'd9, 32'hCC);
    step(); drive_lu(5'd9, 32'hCC); drive_wb(5'd9, 32'hDD); sample();
    idle_cycles(3);

    // r0 on both sources
    step(); drive_lu(5'd0, 32'h55); drive_wb(5'd0, 32'h77); sample();
    check("r0_ready", 64'(lu_ready_o), 64'(1));
    step(); idle_inputs(); sample();
    check("r0_nopush", 64'(busy_o), 64'(0));
    check("r0_nowr", 64'(rf_we_o), 64'(0));
    step(); sample();
    check("r0_nowr2", 64'(rf_we_o), 64'(0));
    check("r0_ready2", 64'(lu_ready_o), 64'(1));

    // Reset with two entries queued
    exp_push(5'd2, 32'hF0);
    exp_push(5'd2, 32'hF1);
    step(); drive_wb(5'd2, 32'hF0); drive_lu(5'd13, 32'hD13); sample();
    step(); drive_wb(5'd2, 32'hF1); drive_lu(5'd14, 32'hD14); sample();
    step(); idle_inputs(); reset = 1'b1; sample();
    check("mr_busy", 64'(busy_o), 64'(1));
    step(); reset = 1'b0; sample();
    check_all_zero("mr");
    idle_cycles(8);
    check("mr_busy_after", 64'(busy_o), 64'(0));
    check("mr_ready_after", 64'(lu_ready_o), 64'(1));

    check("sb_empty", 64'(exp_q.size()), 64'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
